// File: rtl/fetch_predictor_if.sv
// Fetch-stage bus: execute-side redirect/training inputs and fetch PC/prediction outputs.
// master = pipeline/execute side, slave = fetch_predictor.
interface fetch_predictor_if;
  logic        Stall_En;
  logic        Mispredict_E;
  logic [31:0] Redirect_PC_E;
  logic        Branch_Valid_E;
  logic        Branch_Taken_E;
  logic [31:0] Branch_PC_E;
  logic [31:0] Branch_Target_E;
  logic [31:0] PC_F;
  logic [31:0] PC_Plus_4_F;
  logic        Predict_Taken_F;

  modport master (
    output Stall_En, Mispredict_E, Redirect_PC_E,
    output Branch_Valid_E, Branch_Taken_E, Branch_PC_E, Branch_Target_E,
    input  PC_F, PC_Plus_4_F, Predict_Taken_F
  );

  modport slave (
    input  Stall_En, Mispredict_E, Redirect_PC_E,
    input  Branch_Valid_E, Branch_Taken_E, Branch_PC_E, Branch_Target_E,
    output PC_F, PC_Plus_4_F, Predict_Taken_F
  );
endinterface

// File: rtl/fetch_predictor.sv
// Fetch-stage PC generator with a direct-mapped BTB of 2-bit saturating counters,
// trained and redirected by execute-stage branch resolution.
module fetch_predictor #(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input logic               CLK,
  input logic               RST,
  fetch_predictor_if.slave  bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]            r_pc;
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [1:0]             r_cnt [BTB_ENTRIES];
  logic [TAG_W-1:0]       r_tag [BTB_ENTRIES];
  logic [29:0]            r_tgt [BTB_ENTRIES];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_pred;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_pc_nxt;
  logic [IDX_W-1:0] w_bidx;
  logic [TAG_W-1:0] w_btag;
  logic             w_bhit;
  logic             w_unused;

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Lookup on the current fetch PC sees pre-update BTB contents
  assign w_idx      = r_pc[IDX_W+1:2];
  assign w_tag      = r_pc[31:IDX_W+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pred     = w_hit && r_cnt[w_idx][1];
  assign w_pc_plus4 = r_pc + 32'd4;

  assign w_bidx = bus.Branch_PC_E[IDX_W+1:2];
  assign w_btag = bus.Branch_PC_E[31:IDX_W+2];
  assign w_bhit = r_valid[w_bidx] && (r_tag[w_bidx] == w_btag);

  // Address low bits are architecturally ignored
  assign w_unused = ^{bus.Redirect_PC_E[1:0], bus.Branch_PC_E[1:0], bus.Branch_Target_E[1:0]};

  always_comb begin
    w_pc_nxt = w_pc_plus4;
    if (bus.Mispredict_E)
      w_pc_nxt = {bus.Redirect_PC_E[31:2], 2'b00};
    else if (bus.Stall_En)
      w_pc_nxt = r_pc;
    else if (w_pred)
      w_pc_nxt = {r_tgt[w_idx], 2'b00};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pc    <= RESET_PC;
      r_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++)
        r_cnt[i] <= 2'b01;
    end else begin
      r_pc <= w_pc_nxt;
      if (bus.Branch_Valid_E) begin
        if (w_bhit) begin
          r_cnt[w_bidx] <= bus.Branch_Taken_E ? cnt_inc(r_cnt[w_bidx]) : cnt_dec(r_cnt[w_bidx]);
        end else if (bus.Branch_Taken_E) begin
          r_valid[w_bidx] <= 1'b1;
          r_cnt[w_bidx]   <= 2'b10;
        end
      end
    end
  end

  // Tag/target storage needs no reset; entries are qualified by r_valid
  always_ff @(posedge CLK) begin
    if (RST && bus.Branch_Valid_E && bus.Branch_Taken_E) begin
      r_tgt[w_bidx] <= bus.Branch_Target_E[31:2];
      if (!w_bhit)
        r_tag[w_bidx] <= w_btag;
    end
  end

  assign bus.PC_F            = r_pc;
  assign bus.PC_Plus_4_F     = w_pc_plus4;
  assign bus.Predict_Taken_F = w_pred;
endmodule

// File: tb/tb_fetch_predictor.sv
// Randomized and directed bench for fetch_predictor against a behavioural BTB/PC model.
module tb_fetch_predictor;
  localparam int          N   = 16;
  localparam logic [31:0] RPC = 32'h0;

  logic CLK;
  logic RST;
  fetch_predictor_if bus();

  fetch_predictor #(.BTB_ENTRIES(N), .RESET_PC(RPC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Model: each BTB slot remembers the full aligned PC of the branch that owns it
  logic [31:0] m_pc;
  bit          m_v   [N];
  logic [31:0] m_bpc [N];
  logic [31:0] m_tgt [N];
  int          m_cnt [N];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 32'(N));
  endfunction

  function automatic bit m_pred();
    int i;
    i = idx_of(m_pc);
    return m_v[i] && (m_bpc[i] == m_pc) && (m_cnt[i] >= 2);
  endfunction

  task automatic model_reset();
    m_pc = RPC;
    for (int i = 0; i < N; i++) begin
      m_v[i]   = 1'b0;
      m_bpc[i] = '0;
      m_tgt[i] = '0;
      m_cnt[i] = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input bit stall, input bit mis, input logic [31:0] rpc,
                      input bit bv, input bit bt, input logic [31:0] bpc, input logic [31:0] btgt);
    logic [31:0] nxt;
    logic [31:0] a;
    int          i;
    bus.Stall_En        = stall;
    bus.Mispredict_E    = mis;
    bus.Redirect_PC_E   = rpc;
    bus.Branch_Valid_E  = bv;
    bus.Branch_Taken_E  = bt;
    bus.Branch_PC_E     = bpc;
    bus.Branch_Target_E = btgt;
    #3;
    check("pc_f", bus.PC_F, m_pc);
    check("pc_plus4", bus.PC_Plus_4_F, m_pc + 32'd4);
    check("pred", {31'b0, bus.Predict_Taken_F}, {31'b0, m_pred()});
    if (mis)            nxt = {rpc[31:2], 2'b00};
    else if (stall)     nxt = m_pc;
    else if (m_pred())  nxt = m_tgt[idx_of(m_pc)];
    else                nxt = m_pc + 32'd4;
    @(posedge CLK);
    #1;
    m_pc = nxt;
    if (bv) begin
      a = {bpc[31:2], 2'b00};
      i = idx_of(a);
      if (m_v[i] && m_bpc[i] == a) begin
        if (bt) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = {btgt[31:2], 2'b00};
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (bt) begin
        m_v[i]   = 1'b1;
        m_bpc[i] = a;
        m_tgt[i] = {btgt[31:2], 2'b00};
        m_cnt[i] = 2;
      end
    end
    bus.Stall_En       = 1'b0;
    bus.Mispredict_E   = 1'b0;
    bus.Branch_Valid_E = 1'b0;
    bus.Branch_Taken_E = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic redirect(input logic [31:0] a);
    tick(1'b0, 1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    tick(1'b0, 1'b0, 32'h0, 1'b1, taken, pc, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0;
    bus.Stall_En        = 1'b0;
    bus.Mispredict_E    = 1'b0;
    bus.Redirect_PC_E   = 32'h0;
    bus.Branch_Valid_E  = 1'b0;
    bus.Branch_Taken_E  = 1'b0;
    bus.Branch_PC_E     = 32'h0;
    bus.Branch_Target_E = 32'h0;
    model_reset();
    #2;
    check("rst_pc", bus.PC_F, RPC);
    check("rst_pc4", bus.PC_Plus_4_F, RPC + 32'd4);
    check("rst_pred", {31'b0, bus.Predict_Taken_F}, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    idle(); check("free_pc4", bus.PC_F, 32'h4);
    idle(); check("free_pc8", bus.PC_F, 32'h8);
    idle(); check("free_pcC", bus.PC_F, 32'hC);

    train(32'h10, 1'b1, 32'h40);
    redirect(32'h10);
    check("hit_pred", {31'b0, bus.Predict_Taken_F}, 32'h1);
    idle(); check("hit_target", bus.PC_F, 32'h40);

    train(32'h10, 1'b0, 32'h0);
    train(32'h10, 1'b0, 32'h0);
    redirect(32'h10);
    check("nt_pred", {31'b0, bus.Predict_Taken_F}, 32'h0);
    idle(); check("nt_fallthru", bus.PC_F, 32'h14);

    tick(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0);
    check("stall_mispredict", bus.PC_F, 32'h200);

    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h100);
      check("stall_hold", bus.PC_F, 32'h200);
    end
    redirect(32'h8);
    check("stall_trained", {31'b0, bus.Predict_Taken_F}, 32'h1);
    idle(); check("stall_trained_tgt", bus.PC_F, 32'h100);

    train(32'h10, 1'b1, 32'h40);
    train(32'h10 + 32'(4 * N), 1'b1, 32'h80);
    redirect(32'h10);
    check("alias_pred", {31'b0, bus.Predict_Taken_F}, 32'h0);
    idle(); check("alias_pc", bus.PC_F, 32'h14);

    redirect(32'hFFFF_FFFF);
    check("wrap_pc", bus.PC_F, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.PC_Plus_4_F, 32'h0);
    idle(); check("wrap_next", bus.PC_F, 32'h0);

    train(32'h10, 1'b1, 32'h40);
    redirect(32'h10);
    check("pre_rst_pred", {31'b0, bus.Predict_Taken_F}, 32'h1);
    #1;
    RST = 1'b0;
    #1;
    check("mid_rst_pc", bus.PC_F, RPC);
    check("mid_rst_pred", {31'b0, bus.Predict_Taken_F}, 32'h0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    redirect(32'h10);
    idle();

    for (int k = 0; k < 300; k++) begin
      bit          st, mi, bv, bt;
      logic [31:0] rpc, bpc, btgt;
      st   = ($urandom % 4) == 0;
      mi   = ($urandom % 10) == 0;
      rpc  = ($urandom_range(0, 40) * 4) | ($urandom % 4);
      bv   = ($urandom % 5) < 2;
      bt   = $urandom % 2;
      bpc  = ($urandom_range(0, 31) * 4) + ((($urandom % 4) == 0) ? 32'(4 * N) : 32'h0);
      btgt = ($urandom_range(0, 63) * 4) | ($urandom % 4);
      tick(st, mi, rpc, bv, bt, bpc, btgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
